// File: rtl/aes128_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_key_sched_ctrl
//   Iterative AES-128 key expansion. A start pulse captures the cipher key,
//   then one round key per clock is derived and written into an internal
//   11 x 128 round-key file (entries 0..10). Each cycle, the SubWord step runs
//   through four S-box instances.
//
// Ports
//   clk         in   1    system clock, rising edge
//   rst         in   1    synchronous, active-high reset
//   start       in   1    expansion request, sampled only while idle
//   key_in      in   128  cipher key, w0 in [127:96] .. w3 in [31:0]
//   busy        out  1    expansion in progress
//   done        out  1    one-cycle pulse after round key 10 is written
//   keys_valid  out  1    sticky: all 11 round keys are valid
//   rd_addr     in   4    round-key index 0..10 (11..15 read as zero)
//   rd_key      out  128  round key at rd_addr (same word order as key_in)
//   state_dbg   out  1    current FSM state (0 = IDLE, 1 = EXPAND)
//
// Handshake: start is a single-cycle request with no back-pressure signal.
// It is accepted only on a clock edge where the FSM is IDLE (busy low).
// Otherwise it is dropped and does not affect state or keys. The done cycle
// is already IDLE, so a start in that cycle is accepted.
// ---------------------------------------------------------------------------

// Single AES S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes128_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x254;

  // The inverse is x^254 (maps 0 to 0), built from a short addition chain.
  always_comb begin
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x254 = gf_mul(gf_mul(x240, x12), x2);
  end

  // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  assign y = x254
           ^ {x254[6:0], x254[7]}
           ^ {x254[5:0], x254[7:6]}
           ^ {x254[4:0], x254[7:5]}
           ^ {x254[3:0], x254[7:4]}
           ^ 8'h63;

endmodule

module aes128_key_sched_ctrl #(
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         state_dbg
);

  localparam int NUM_RK = 11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [127:0] rk [NUM_RK];
  logic [127:0] w_reg;
  logic [127:0] next_w;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         accept;
  logic         last_rnd;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rd_mux;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  assign accept   = (state == S_IDLE) && start;
  assign last_rnd = (rnd == 4'd10);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start)    state_next = S_EXPAND;
      S_EXPAND: if (last_rnd) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state == S_EXPAND);
    state_dbg = state;
  end

  // ---------------- Round function ----------------
  // RotWord on w3 (byte 0 at MSB), then SubWord through the four S-boxes.
  assign rot_w3 = {w_reg[23:0], w_reg[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes128_sbox u_sbox (
      .x(rot_w3[8*g +: 8]),
      .y(sub_w3[8*g +: 8])
    );
  end

  assign t_word = sub_w3 ^ {rcon, 24'h0};
  assign n0     = w_reg[127:96] ^ t_word;
  assign n1     = w_reg[95:64]  ^ n0;
  assign n2     = w_reg[63:32]  ^ n1;
  assign n3     = w_reg[31:0]   ^ n2;
  assign next_w = {n0, n1, n2, n3};

  // ---------------- Datapath and key file ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg      <= '0;
      rnd        <= '0;
      rcon       <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        w_reg      <= key_in;
        rk[0]      <= key_in;
        rnd        <= 4'd1;
        rcon       <= 8'h01;
        keys_valid <= 1'b0;
      end else if (state == S_EXPAND) begin
        for (int i = 1; i < NUM_RK; i++) begin
          if (rnd == 4'(i)) rk[i] <= next_w;
        end
        w_reg <= next_w;
        rcon  <= xtime(rcon);
        if (last_rnd) begin
          keys_valid <= 1'b1;
          done       <= 1'b1;
          rnd        <= 4'd0;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

  // ---------------- Read port ----------------
  // Addresses beyond the last round key fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rd_addr == 4'(i)) rd_mux = rk[i];
    end
  end

  if (RD_REG) begin : g_rd_reg
    // Registered read: samples the pre-edge file contents, so a read of an
    // entry being written on the same edge returns the old value.
    always_ff @(posedge clk) begin
      if (rst) rd_key <= '0;
      else     rd_key <= rd_mux;
    end
  end else begin : g_rd_comb
    assign rd_key = rd_mux;
  end

endmodule
